mux_scan_seq: RTL and testbench

Scan sequencer for the N:1 multiplexers in this library (2x1 and wider). It drives the mux select lines, waits a programmable settle time on each channel, and captures the mux output into a per-channel sample register, giving a full snapshot of all mux inputs. It sits directly upstream of the mux on `s` and directly downstream of it on `y`, and reports completion with a start/busy/done handshake.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_dwell_cnt.sv | 36 +++
 rtl/mux_scan_seq.sv | 136 +++++++++++++
 tb/tb_mux_scan_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sequencer: FSM state codes and
// synchronizer depth used when mux inputs are asynchronous to clk.
package mux_scan_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable settle down-counter; load wins over dec, dec stops at zero.
// Ports: clk, rst (async high), load, load_val[W], dec -> zero.
module mux_scan_dwell_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Scan sequencer: steps mux select s over all N channels, waits the
// settle time, captures y into sample[s]; start/busy/done handshake.
// Ports: clk, rst (async high), start, dwell[DWELL_W], y -> s[SEL_W],
//   busy, done, sample[2**SEL_W].
// Option MUX_SCAN_SYNC_EN: 2-flop y synchronizer, settle load dwell+2.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int SEL_W   = 1,
    parameter int DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                y,
    output logic [SEL_W-1:0]    s,
    output logic                busy,
    output logic                done,
    output logic [2**SEL_W-1:0] sample
);

    localparam int N  = 2**SEL_W;
    localparam int CW = DWELL_W + 1;
    localparam logic [SEL_W-1:0] S_LAST = SEL_W'(N - 1);

`ifdef MUX_SCAN_SYNC_EN
    localparam logic [CW-1:0] SETTLE_EXTRA = CW'(2);
`else
    localparam logic [CW-1:0] SETTLE_EXTRA = CW'(0);
`endif

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic [N-1:0]       sample_q, sample_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [DWELL_W-1:0] ld_src;
    logic [CW-1:0]      cnt_ld_val;
    logic               y_cap;

`ifdef MUX_SCAN_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], y};
    assign y_cap  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign y_cap = y;
`endif

    // Width-extended so dwell all-ones (+2) never wraps.
    assign cnt_ld_val = {1'b0, ld_src} + SETTLE_EXTRA;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        sample_d = sample_q;
        dwell_d  = dwell_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        ld_src   = dwell_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    s_d      = '0;
                    dwell_d  = dwell;
                    ld_src   = dwell;
                    cnt_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CAPTURE: begin
                sample_d[s_q] = y_cap;
                if (s_q == S_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    s_d      = s_q + SEL_W'(1);
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            sample_q <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            sample_q <= sample_d;
            dwell_q  <= dwell_d;
        end
    end

    mux_scan_dwell_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign s      = s_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Randomized self-checking bench for mux_scan_seq (SEL_W=2) against a
// cycle-index timing model and a behavioural 4:1 mux.
module tb_mux_scan_seq;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;
    localparam int N       = 2**SEL_W;
`ifdef MUX_SCAN_SYNC_EN
    localparam int EX = 2;
`else
    localparam int EX = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic               y;
    logic [SEL_W-1:0]   s;
    logic               busy;
    logic               done;
    logic [N-1:0]       sample;
    logic [N-1:0]       mux_in;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign y = mux_in[s];

    mux_scan_seq #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dwell  (dwell),
        .y      (y),
        .s      (s),
        .busy   (busy),
        .done   (done),
        .sample (sample)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Channel being visited in cycle c of a scan: each channel takes
    // d+2(+EX) cycles; s parks on the last channel afterwards.
    function automatic int exp_s(input int c, input int d);
        int ch;
        ch = (c - 1) / (d + 2 + EX);
        if (ch > N - 1) ch = N - 1;
        return ch;
    endfunction

    task automatic run_scan(input int d, input logic [N-1:0] pat,
                            input bit noise, input bit chain,
                            input int nd, input bit skip);
        int t;
        t = 1 + N * (d + 2 + EX);
        if (!skip) begin
            @(negedge clk);
            mux_in = pat;
            dwell  = DWELL_W'(d);
            start  = 1'b1;
        end
        for (int c = 1; c <= t + 1; c++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(c <= t));
            chk("done", 32'(done), 32'(c == t));
            chk("s", 32'(s), 32'(exp_s(c, d)));
            if (c == t + 1) chk("sample", 32'(sample), 32'(pat));
            if (chain && c == t + 1) begin
                start = 1'b1;
                dwell = DWELL_W'(nd);
            end else if (noise && c < t) begin
                start = 1'($urandom_range(0, 1));
                dwell = DWELL_W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        dwell  = '0;
        mux_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_scan(0, 4'b1101, 1'b0, 1'b0, 0, 1'b0);
        run_scan(3, 4'b0110, 1'b0, 1'b0, 0, 1'b0);
        run_scan(1, 4'b1010, 1'b0, 1'b0, 0, 1'b0);
        run_scan(15, 4'b0011, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_scan(int'($urandom_range(0, 5)), N'($urandom),
                     1'b1, 1'b0, 0, 1'b0);
        end

        // start held through DONE re-arms on the first IDLE cycle
        run_scan(2, 4'b1001, 1'b0, 1'b1, 1, 1'b0);
        run_scan(1, 4'b1001, 1'b0, 1'b0, 0, 1'b1);

        // async reset mid-scan
        @(negedge clk);
        mux_in = 4'b1111;
        dwell  = DWELL_W'(2);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_s", 32'(s), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sample", 32'(sample), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", 32'(done), 32'd0);
            chk("rst_hold_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        run_scan(1, 4'b0101, 1'b0, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
